// File: rtl/ehl_clk_div.sv
// rtl/ehl_clk_div.sv - runtime-programmable clock divider with runt-free divisor changes (optional EHL_CLK_DIV_HALF_CYCLE_EN)

// Two-input XOR used to merge the posedge and negedge toggle flops.
module ehl_xor #(
    parameter int TECHNOLOGY = 0
) (
    input  logic a,
    input  logic b,
    output logic y
);

    generate
        if (TECHNOLOGY == 0) begin : g_generic
            // Plain RTL XOR.
            assign y = a ^ b;
        end else begin : g_mapped
            // Sum-of-products form that maps onto the cell library's AO22-style gates.
            assign y = (a & ~b) | (~a & b);
        end
    endgenerate

endmodule

module ehl_clk_div #(
    parameter int TECHNOLOGY = 0,
    parameter int WIDTH      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_div,
    input  logic             i_load,
    output logic             o_busy,
    output logic             o_clk,
    output logic             o_tick
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] pend_q;
    logic [WIDTH-1:0] d_eff;
    logic [WIDTH-1:0] k_val;
    logic [WIDTH-1:0] d_last;
    logic             d_odd;
    logic             t_p;
    logic             tp_d;
    logic             t_n;
    logic             at_last;
    logic             fall_p;
    logic             consume;
    logic             accept;

    // Divisors below 2 cannot form a clock, so they run as divide-by-2.
    assign d_eff   = (div_q < WIDTH'(2)) ? WIDTH'(2) : div_q;
    assign k_val   = d_eff >> 1;
    assign d_last  = d_eff - WIDTH'(1);
    assign d_odd   = d_eff[0];
    assign at_last = (state_q == ST_RUN) && (cnt_q == d_last);
    assign o_tick  = at_last;

`ifdef EHL_CLK_DIV_HALF_CYCLE_EN
    // Odd divisors fall on the negedge flop instead; only even ones fall here.
    assign fall_p = !d_odd && (cnt_q == k_val - WIDTH'(1));
`else
    // Odd divisors keep the extra half cycle in the high phase.
    assign fall_p = d_odd ? (cnt_q == k_val) : (cnt_q == k_val - WIDTH'(1));
`endif

    // A pending divisor may be taken at the same edge a new one is captured.
    assign accept = i_load && (!o_busy || consume);

    // Next-state, counter and posedge-toggle decisions.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tp_d    = t_p;
        consume = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d   = '0;
                consume = o_busy;
                if (i_en) begin
                    tp_d    = ~t_p;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (at_last) begin
                    cnt_d = '0;
                    if (i_en) begin
                        tp_d    = ~t_p;
                        consume = o_busy;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                    if (fall_p) begin
                        tp_d = ~t_p;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter, posedge toggle and divisor bookkeeping registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            t_p     <= 1'b0;
            div_q   <= WIDTH'(2);
            pend_q  <= '0;
            o_busy  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t_p     <= tp_d;
            if (consume) begin
                div_q <= pend_q;
            end
            if (accept) begin
                pend_q <= i_div;
            end
            o_busy <= accept || (o_busy && !consume);
        end
    end

`ifdef EHL_CLK_DIV_HALF_CYCLE_EN
    // Negedge toggle mid-way through the middle count of an odd period.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            t_n <= 1'b0;
        end else if ((state_q == ST_RUN) && d_odd && (cnt_q == k_val)) begin
            t_n <= ~t_n;
        end
    end
`else
    assign t_n = 1'b0;
`endif

    ehl_xor #(
        .TECHNOLOGY(TECHNOLOGY)
    ) u_xor (
        .a(t_p),
        .b(t_n),
        .y(o_clk)
    );

endmodule

// File: doc/ehl_clk_div.md
# ehl_clk_div

Parametrised clock divider producing a divided clock from one source clock. The integer divisor is runtime-programmable and changes are applied only at period boundaries, so the output never carries a runt pulse. The output is built as the XOR of a posedge toggle flop and an optional negedge toggle flop through an `ehl_xor` instance, which allows odd divisors to reach a 50% duty cycle. The block sits in the techmap clocking set, beside `ehl_xor`, and is shared by RTL and mapped builds.

## Interface
- TECHNOLOGY, 0, technology select forwarded to the internal `ehl_xor`; 0 = generic RTL
- WIDTH, 8, divisor width in bits

- clk  in  1  source clock
- reset  in  1  asynchronous, active-high reset
- i_en  in  1  run request, level sensitive
- i_div  in  WIDTH  requested divisor, unsigned
- i_load  in  1  one-cycle strobe that captures i_div
- o_busy  out  1  a captured divisor is pending
- o_clk  out  1  divided clock, t_p XOR t_n
- o_tick  out  1  high in the last clk cycle of each running period

## Operation
- Registers and reset values (all clear asynchronously while reset=1):
  - state = IDLE, cnt = 0, t_p = 0, t_n = 0
  - div_q = 2, pend_q = 0, o_busy = 0
  - o_clk = 0 and o_tick = 0 immediately.
- Effective divisor: D = 2 when div_q < 2, else D = div_q. Define k = floor(D/2). cnt is WIDTH bits and counts 0..D-1.
- IDLE state:
  - cnt holds 0; o_clk = 0 (t_p = t_n); o_tick = 0.
  - If o_busy=1, div_q <= pend_q on the next posedge and o_busy clears.
  - When i_en=1 at a posedge: t_p toggles (o_clk rises), cnt <= 0, state <= RUN. A pending divisor applied in the same edge takes effect for this period.
- RUN state, each posedge:
  - If cnt != D-1: cnt <= cnt+1.
  - Even D: t_p also toggles when cnt == k-1, so o_clk falls as cnt becomes k. High time is k cycles.
- RUN state, boundary (cnt == D-1, o_tick = 1):
  - If i_en=1: cnt <= 0 and t_p toggles (rising edge). If o_busy=1, div_q <= pend_q and o_busy clears in the same edge.
  - If i_en=0: state <= IDLE, cnt <= 0, no toggle. The pending divisor is applied on the next IDLE cycle.
- Divisor capture:
  - i_load with o_busy=0: pend_q <= i_div, o_busy <= 1 on the next edge.
  - i_load with o_busy=1: ignored; pend_q is unchanged.
- Deasserting i_en never truncates a period: the current period completes, and o_clk is already low at the boundary.

## Timing
- i_en sampled high in IDLE → o_clk rises one flop delay after that same edge.
- Period is D clk cycles. o_tick asserts for 1 cycle, D-1 cycles after each rising output edge.
- i_load accepted in RUN → new D applies at the next boundary. Worst-case latency is D_old cycles.
- Simultaneous i_load and boundary: the boundary applies the previous pend_q (if any), then the new value is captured and o_busy stays 1.
- reset asserted mid-high phase → o_clk drops without waiting for a clk edge.

## Configuration
- EHL_CLK_DIV_HALF_CYCLE_EN defined:
  - A negedge flop t_n (async reset 0) is built.
  - For odd D = 2k+1, t_p toggles only at the boundary, and t_n toggles on the negedge while cnt == k.
  - o_clk is high for k+0.5 cycles, i.e. exactly 50% duty.
- Not defined:
  - t_n is tied to 0 and no negedge logic exists.
  - For odd D, t_p toggles at the boundary and again as cnt becomes k+1, giving k+1 cycles high and k low.
- Even D behaves identically in both builds.

## Test plan
- Reset, then i_div=4 with i_load, then i_en=1 → o_clk period 4 clk (2 high, 2 low); o_tick high 1 cycle in every 4.
- i_div=5:
  - With EHL_CLK_DIV_HALF_CYCLE_EN: 20-unit clk gives 50 units high, 50 units low.
  - Without the macro: 60 units high, 40 units low.
- i_div 4→3 loaded when cnt=1 → current 4-cycle period completes and the next period is 3 cycles. o_busy is high from the edge after the load until the boundary. A second i_load (value 7) while busy is ignored.
- i_div=0, then i_div=1 → each behaves as D=2 (1 cycle high, 1 cycle low).
- i_en dropped at cnt=1 of a D=4 period → period finishes, o_clk stays 0, o_tick stops. Re-raising i_en → o_clk rises on the first sampling edge.
- Reset pulsed while o_clk=1 → o_clk, o_busy and o_tick are 0 within the reset pulse. TECHNOLOGY=0 and TECHNOLOGY=1 instances run side by side give bit-identical o_clk throughout.
